led_sweep_ctrl: RTL and testbench

// - Sequencer for the 9-bit switch-to-LED bank: owns o_led and chooses its source.
// - PASS mode: synchronised switches drive the LEDs through the fixed bank mapping.
// - SWEEP mode: a single lit LED walks up the bank and back, one step per prescaler tick.
// - Sits between the board switch/button pins and the LED pins at top level.
//

---
 rtl/led_sweep_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_led_sweep_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sweep_ctrl.sv
// led_sweep_ctrl: LED bank sequencer, switch pass-through or walking-LED sweep.
// Ports: i_clk, i_reset_n (async low), i_sw/i_go raw pins, o_led/o_busy regs. Opt: LED_SWEEP_LOOP_EN.
module led_sweep_ctrl #(
  parameter int NLEDS   = 9,
  parameter int HALF    = 5,
  parameter int CLK_DIV = 12000000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [NLEDS-1:0] i_sw,
  input  logic             i_go,
  output logic [NLEDS-1:0] o_led,
  output logic             o_busy
);

  localparam int PW = $clog2(NLEDS);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] POS_MAX = PW'(NLEDS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [NLEDS-1:0] ONE =
    {{(NLEDS-1){1'b0}}, 1'b1};

`ifdef LED_SWEEP_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_PASS,
    S_UP,
    S_DN
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       rst_q, rst_d;
  logic             rst_n;
  logic [NLEDS-1:0] sw_meta_q, sw_meta_d;
  logic [NLEDS-1:0] sw_s_q, sw_s_d;
  logic             go_meta_q, go_meta_d;
  logic             go_s_q, go_s_d;
  logic             go_dly_q, go_dly_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NLEDS-1:0] led_q, led_d;
  logic             busy_q, busy_d;

  logic [NLEDS-1:0] led_map;
  logic             go_rise;
  logic             tick;

  // Release of the internal reset is retimed to i_clk.
  assign rst_d = {rst_q[0], 1'b1};
  assign rst_n = rst_q[1];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rst_q <= '0;
    else            rst_q <= rst_d;
  end

  always_comb begin
    sw_meta_d = i_sw;
    sw_s_d    = sw_meta_q;
    go_meta_d = i_go;
    go_s_d    = go_meta_q;
    go_dly_d  = go_s_q;
  end

  assign go_rise = go_s_q & ~go_dly_q;
  assign tick    = (cnt_q == CNT_MAX);

  // Upper half of the bank is wired in reverse order.
  for (genvar k = 0; k < NLEDS; k++) begin : g_map
    if (k < HALF) begin : g_lo
      assign led_map[k] = sw_s_q[k];
    end else begin : g_hi
      assign led_map[k] = sw_s_q[NLEDS-1-(k-HALF)];
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_PASS;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_PASS: if (go_rise) state_d = S_UP;
      S_UP: begin
        if (tick && pos_q == POS_MAX)
          state_d = S_DN;
      end
      S_DN: begin
        if (tick && pos_q == '0)
          state_d = (LOOP_EN && go_s_q) ? S_UP : S_PASS;
      end
      default: state_d = S_PASS;
    endcase
  end

  always_comb begin
    pos_d  = pos_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    busy_d = busy_q;
    unique case (state_q)
      S_PASS: begin
        cnt_d = '0;
        pos_d = '0;
        if (go_rise) begin
          led_d  = ONE;
          busy_d = 1'b1;
        end else begin
          led_d  = led_map;
          busy_d = 1'b0;
        end
      end
      S_UP: begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          if (pos_q == POS_MAX) pos_d = pos_q - PW'(1);
          else                  pos_d = pos_q + PW'(1);
          led_d = ONE << pos_d;
        end
      end
      S_DN: begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          if (pos_q == '0) begin
            if (LOOP_EN && go_s_q) begin
              pos_d = '0;
              led_d = ONE;
            end else begin
              led_d  = led_map;
              busy_d = 1'b0;
            end
          end else begin
            pos_d = pos_q - PW'(1);
            led_d = ONE << pos_d;
          end
        end
      end
      default: begin
        cnt_d  = '0;
        pos_d  = '0;
        led_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
      go_meta_q <= 1'b0;
      go_s_q    <= 1'b0;
      go_dly_q  <= 1'b0;
      pos_q     <= '0;
      cnt_q     <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_s_q    <= sw_s_d;
      go_meta_q <= go_meta_d;
      go_s_q    <= go_s_d;
      go_dly_q  <= go_dly_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// tb_led_sweep_ctrl: bench for led_sweep_ctrl (NLEDS=9, HALF=5, CLK_DIV=4).
// Table vectors, directed sweep/reset/hold sequences, random stimulus vs model.
module tb_led_sweep_ctrl;

  localparam int NL = 9;
  localparam int HF = 5;
  localparam int CD = 4;
  localparam int RT = (2 * (NL - 1) + 1) * CD;

`ifdef LED_SWEEP_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic [NL-1:0] i_sw = '0;
  logic          i_go = 1'b0;
  logic [NL-1:0] o_led;
  logic          o_busy;

  always #5 clk = ~clk;

  led_sweep_ctrl #(
    .NLEDS  (NL),
    .HALF   (HF),
    .CLK_DIV(CD)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(i_reset_n),
    .i_sw     (i_sw),
    .i_go     (i_go),
    .o_led    (o_led),
    .o_busy   (o_busy)
  );

  function automatic logic [NL-1:0] map_sw(input logic [NL-1:0] s);
    logic [NL-1:0] r;
    for (int k = 0; k < NL; k++) begin
      if (k < HF) r[k] = s[k];
      else        r[k] = s[NL-1-(k-HF)];
    end
    return r;
  endfunction

  // Sweep LED pattern t cycles after sweep entry.
  function automatic logic [NL-1:0] sweep_led(input int t);
    logic [NL-1:0] one;
    int st;
    int p;
    one = 1;
    st  = t / CD;
    p   = (st <= NL - 1) ? st : 2 * (NL - 1) - st;
    return one << p;
  endfunction

  int            rcnt = 0;
  logic [NL-1:0] m_sw1 = '0, m_sw_s = '0;
  logic          m_go1 = 0, m_go_s = 0, m_go_q = 0;
  logic          m_busy = 0;
  logic [NL-1:0] m_led = '0;
  int            m_t = 0;
  logic          rise;

  always @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n || rcnt < 2) begin
      if (!i_reset_n) rcnt = 0;
      else            rcnt++;
      m_sw1 = '0; m_sw_s = '0;
      m_go1 = 0; m_go_s = 0; m_go_q = 0;
      m_busy = 0; m_led = '0; m_t = 0;
    end else begin
      rise = m_go_s && !m_go_q;
      if (!m_busy) begin
        if (rise) begin
          m_busy = 1; m_t = 0; m_led = sweep_led(0);
        end else begin
          m_led = map_sw(m_sw_s);
        end
      end else begin
        m_t++;
        if (m_t == RT) begin
          if (LOOP && m_go_s) begin
            m_t = 0; m_led = sweep_led(0);
          end else begin
            m_busy = 0; m_led = map_sw(m_sw_s);
          end
        end else begin
          m_led = sweep_led(m_t);
        end
      end
      m_go_q = m_go_s; m_go_s = m_go1; m_go1 = i_go;
      m_sw_s = m_sw1;  m_sw1 = i_sw;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_prt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare against the model.
  task automatic step();
    @(negedge clk);
    n_cmp++;
    if (o_led !== m_led || o_busy !== m_busy) begin
      n_bad++;
      if (n_prt < 20)
        $display("FAIL model: led=0x%0h busy=%0b want led=0x%0h busy=%0b at %0t",
                 o_led, o_busy, m_led, m_busy, $time);
      n_prt++;
    end
  endtask

  task automatic wait_busy(input logic lvl, input int max);
    int n;
    n = 0;
    while (o_busy !== lvl && n < max) begin
      step();
      n++;
    end
    if (o_busy !== lvl) chk("wait_busy_timeout", o_busy, lvl);
  endtask

  typedef struct {
    logic [NL-1:0] sw;
    logic [NL-1:0] led;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [NL-1:0] prev;
    int k, busy_n, rises;
    logic pb;

    tbl[0] = '{9'h101, 9'h021};
    tbl[1] = '{9'h0E0, 9'h1C0};
    tbl[2] = '{9'h1FF, 9'h1FF};
    tbl[3] = '{9'h01F, 9'h01F};
    tbl[4] = '{9'h100, 9'h020};
    tbl[5] = '{9'h020, 9'h100};
    tbl[6] = '{9'h0AA, 9'h14A};
    tbl[7] = '{9'h155, 9'h0B5};

    // Reset held: outputs stay cleared whatever the pins do.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_led", o_led, 0);
      chk("rst_busy", o_busy, 0);
      #1 i_sw = NL'($urandom);
      i_go = 1'($urandom);
    end
    #1 i_sw = '0; i_go = 0;
    step();
    #1 i_reset_n = 1;
    repeat (8) step();

    // Pass-through mapping and 3-cycle latency.
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      #1 i_sw = tbl[i].sw;
      step();
      step();
      chk("map_latency", o_led, prev);
      step();
      chk("map", o_led, tbl[i].led);
      prev = tbl[i].led;
    end

    // Single sweep with a second go pulse mid-sweep.
    #1 i_go = 1;
    step();
    #1 i_go = 0;
    wait_busy(1, 10);
    k = 0;
    while (o_busy === 1'b1 && k < 300) begin
      if (k == 0)  chk("sweep_first", o_led, 9'h001);
      if (k == 4)  chk("sweep_step1", o_led, 9'h002);
      if (k == 32) chk("sweep_top", o_led, 9'h100);
      if (k == 36) chk("sweep_dn", o_led, 9'h080);
      if (k == 64) chk("sweep_last", o_led, 9'h001);
      if (k == 20) #1 i_go = 1;
      if (k == 22) #1 i_go = 0;
      step();
      k++;
    end
    chk("sweep_len", k, RT);
    chk("exit_led", o_led, map_sw(i_sw));
    repeat (30) step();
    chk("no_requeue", o_busy, 0);

    // Reset at pos=5 mid-sweep.
    #1 i_go = 1;
    step();
    #1 i_go = 0;
    wait_busy(1, 10);
    k = 0;
    while (o_led !== 9'h020 && k < 100) begin
      step();
      k++;
    end
    chk("reach_pos5", o_led, 9'h020);
    #1 i_reset_n = 0;
    #1;
    chk("midrst_led", o_led, 0);
    chk("midrst_busy", o_busy, 0);
    i_sw = 9'h101;
    repeat (3) step();
    #1 i_reset_n = 1;
    repeat (6) step();
    chk("post_rst_led", o_led, 9'h021);
    chk("post_rst_busy", o_busy, 0);

    // Button held for 100 cycles.
    busy_n = 0;
    rises = 0;
    pb = 0;
    #1 i_go = 1;
    for (int c = 0; c < 400; c++) begin
      step();
      if (c == 100) #1 i_go = 0;
      if (o_busy) busy_n++;
      if (o_busy && !pb) rises++;
      pb = o_busy;
    end
    chk("hold_busy_cycles", busy_n, LOOP ? 2 * RT : RT);
    chk("hold_sweeps", rises, 1);

    // Random stimulus against the model.
    for (int c = 0; c < 4000; c++) begin
      step();
      #1;
      if (!i_reset_n) i_reset_n = 1;
      else if ($urandom_range(0, 799) == 0) i_reset_n = 0;
      if ($urandom_range(0, 3) == 0) i_sw = NL'($urandom);
      if ($urandom_range(0, 29) == 0) i_go = ~i_go;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
